// File: rtl/q_stream_rx.sv
// Consumer of the Q-matrix serial read interface: fetches one 3x3 matrix from the
// Q generator, checks its end-of-stream flag and replays it on a valid/ready stream.
module q_stream_rx #(
    parameter int SIZE      = 16,
    parameter bit TRANSPOSE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go,
    input  logic            q_done,
    input  logic            q_finish,
    input  logic [SIZE-1:0] q_in,
    output logic            q_read,
    output logic [SIZE-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy,
    output logic            err,
    output logic            rx_done
);

    // Stream handshake: an element transfers on every rising edge where
    // out_valid && out_ready; out_data/out_last hold while out_valid && !out_ready.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]      state;
    logic [3:0]      req_cnt;
    logic [3:0]      wr_idx;
    logic [3:0]      rd_idx;
    logic            rd_pend;
    logic [SIZE-1:0] mem [9];

    logic [3:0]      rd_sel;
    logic            last_cap;
    logic            early_fin;
    logic            out_hs;

    // Output element k of Q^T is Q[k%3][k/3], i.e. the captured column-major order.
    function automatic logic [3:0] map_idx(input logic [3:0] k);
        logic [3:0] m;
        m = 4'd0;
        if (!TRANSPOSE) begin
            m = k;
        end else begin
            case (k)
                4'd0: m = 4'd0;
                4'd1: m = 4'd3;
                4'd2: m = 4'd6;
                4'd3: m = 4'd1;
                4'd4: m = 4'd4;
                4'd5: m = 4'd7;
                4'd6: m = 4'd2;
                4'd7: m = 4'd5;
                4'd8: m = 4'd8;
                default: m = 4'd0;
            endcase
        end
        return m;
    endfunction

    assign rd_sel    = map_idx(rd_idx);
    assign q_read    = (state == S_READ) && (req_cnt < 4'd9);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DRAIN);
    assign out_last  = out_valid && (rd_idx == 4'd8);
    assign out_data  = out_valid ? mem[rd_sel] : '0;
    assign out_hs    = out_valid && out_ready;
    assign last_cap  = rd_pend && (wr_idx == 4'd8);
    // Finish seen with nothing in flight means the generator ran out before nine elements.
    assign early_fin = q_finish && !rd_pend && (req_cnt < 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            req_cnt <= 4'd0;
            wr_idx  <= 4'd0;
            rd_idx  <= 4'd0;
            rd_pend <= 1'b0;
            err     <= 1'b0;
            rx_done <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rx_done <= 1'b0;
            rd_pend <= q_read & ~q_finish;
            if (q_read) begin
                req_cnt <= req_cnt + 4'd1;
            end
            if (rd_pend && (wr_idx < 4'd9)) begin
                mem[wr_idx] <= q_in;
                wr_idx      <= wr_idx + 4'd1;
            end
            case (state)
                S_IDLE: begin
                    if (go) begin
                        err   <= 1'b0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (q_done) begin
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    if (last_cap) begin
                        if (!q_finish) begin
                            err <= 1'b1;
                        end
                        state <= S_DRAIN;
                    end else if (early_fin) begin
                        err     <= 1'b1;
                        state   <= S_IDLE;
                        req_cnt <= 4'd0;
                        wr_idx  <= 4'd0;
                        rd_pend <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (out_hs) begin
                        if (rd_idx == 4'd8) begin
                            state   <= S_IDLE;
                            rx_done <= 1'b1;
                            rd_idx  <= 4'd0;
                            wr_idx  <= 4'd0;
                            req_cnt <= 4'd0;
                            rd_pend <= 1'b0;
                        end else begin
                            rd_idx <= rd_idx + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q_stream_rx.sv
// Bench for q_stream_rx: a behavioural Q generator feeds a transposing and a
// non-transposing instance side by side; a vector table drives whole transfers.
module tb_q_stream_rx;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic        q_done;
    logic        q_finish;
    logic [15:0] q_in;
    logic        out_ready;

    logic        q_read,   q_read0;
    logic [15:0] out_data, out0_data;
    logic        out_valid, out0_valid;
    logic        out_last, out0_last;
    logic        busy, busy0;
    logic        err, err0;
    logic        rx_done, rx_done0;

    q_stream_rx #(.SIZE(16), .TRANSPOSE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .go(go), .q_done(q_done), .q_finish(q_finish),
        .q_in(q_in), .q_read(q_read), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .err(err),
        .rx_done(rx_done)
    );

    q_stream_rx #(.SIZE(16), .TRANSPOSE(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .go(go), .q_done(q_done), .q_finish(q_finish),
        .q_in(q_in), .q_read(q_read0), .out_data(out0_data), .out_valid(out0_valid),
        .out_ready(out_ready), .out_last(out0_last), .busy(busy0), .err(err0),
        .rx_done(rx_done0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q generator model: advances one element per sampled read while finish is low.
    logic [15:0] gen_mem [9];
    int          gen_ptr;
    int          gen_finish_at;
    logic        gen_adv;

    initial gen_adv = 1'b0;
    always @(negedge clk) gen_adv = q_read && !q_finish;
    always @(posedge clk) begin
        if (gen_adv && gen_ptr < 9) begin
            #1;
            q_in     = gen_mem[gen_ptr];
            q_finish = (gen_ptr == gen_finish_at);
            gen_ptr++;
        end
    end

    typedef struct {
        logic [15:0] data [9];
        int          finish_at;
        bit          bp;
        bit          go_in_read;
        bit          exp_err;
        bit          exp_drain;
        int          exp_reads;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] exp_q[$];
    logic [15:0] exp0_q[$];
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q_read"},    {31'd0, q_read},    32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_last"},  {31'd0, out_last},  32'd0);
        check({tag, "_out_data"},  {16'd0, out_data},  32'd0);
        check({tag, "_out0_data"}, {16'd0, out0_data}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
        check({tag, "_err"},       {31'd0, err},       32'd0);
        check({tag, "_rx_done"},   {31'd0, rx_done},   32'd0);
    endtask

    // One complete transfer; abort_at >= 0 asserts reset after that many handshakes.
    task automatic run_case(input int idx, input int abort_at);
        vec_t        v;
        int          hs;
        int          reads;
        int          dones;
        bit          held;
        logic [15:0] held_data;
        bit          finished;
        logic [15:0] e;
        v = vecs[idx];
        for (int k = 0; k < 9; k++) gen_mem[k] = v.data[k];
        gen_ptr       = 0;
        gen_finish_at = v.finish_at;
        q_finish      = 1'b0;
        q_in          = 16'd0;
        exp_q.delete();
        exp0_q.delete();
        if (v.exp_drain) begin
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 3; r++)
                    exp_q.push_back(v.data[3*r + c]);
            for (int k = 0; k < 9; k++) exp0_q.push_back(v.data[k]);
        end
        hs = 0; reads = 0; dones = 0; held = 1'b0; held_data = 16'd0; finished = 1'b0;

        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        #1;
        check($sformatf("v%0d_go_clears_err", idx), {31'd0, err}, 32'd0);
        check($sformatf("v%0d_busy_after_go", idx), {31'd0, busy}, 32'd1);

        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            q_done    = (cyc >= 1 && cyc < 4);
            go        = v.go_in_read && (cyc == 6);
            out_ready = v.bp ? (cyc % 3 == 0) : 1'b1;
            #1;
            if (q_read) reads++;
            if (rx_done) dones++;
            check($sformatf("v%0d_t0_valid_align", idx), {31'd0, out0_valid}, {31'd0, out_valid});
            if (held) begin
                check($sformatf("v%0d_hold_valid", idx), {31'd0, out_valid}, 32'd1);
                check($sformatf("v%0d_hold_data", idx), {16'd0, out_data}, {16'd0, held_data});
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("v%0d_extra_element", idx), 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("v%0d_t1_data%0d", idx, hs), {16'd0, out_data}, {16'd0, e});
                    e = exp0_q.pop_front();
                    check($sformatf("v%0d_t0_data%0d", idx, hs), {16'd0, out0_data}, {16'd0, e});
                end
                check($sformatf("v%0d_last%0d", idx, hs), {31'd0, out_last}, {31'd0, (hs == 8)});
                hs++;
                if (abort_at >= 0 && hs == abort_at) begin
                    @(negedge clk);
                    #2 rst_n = 1'b0;
                    #1 check_reset_outputs($sformatf("v%0d_abort", idx));
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        go = 1'b0;
        q_done = 1'b0;
        check($sformatf("v%0d_no_timeout", idx), {31'd0, finished}, 32'd1);
        check($sformatf("v%0d_handshakes", idx), hs, v.exp_drain ? 32'd9 : 32'd0);
        check($sformatf("v%0d_read_cycles", idx), reads, v.exp_reads);
        check($sformatf("v%0d_rx_done_pulses", idx), dones, v.exp_drain ? 32'd1 : 32'd0);
        check($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.exp_err});
        check($sformatf("v%0d_err_t0", idx), {31'd0, err0}, {31'd0, v.exp_err});
        @(negedge clk);
        #1;
        check($sformatf("v%0d_rx_done_width", idx), {31'd0, rx_done}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        gen_ptr  = 9;
        gen_finish_at = 8;
        rst_n = 1'b0; go = 1'b0; q_done = 1'b0; q_finish = 1'b0; q_in = 16'd0; out_ready = 1'b0;

        vecs[0] = '{data: '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9},
                    finish_at: 8, bp: 1'b0, go_in_read: 1'b0, exp_err: 1'b0, exp_drain: 1'b1, exp_reads: 9};
        vecs[1] = '{data: '{16'h8000, 16'h7FFF, 16'd3, 16'd4, 16'h8000, 16'd6, 16'd7, 16'hFFFF, 16'h7FFF},
                    finish_at: 8, bp: 1'b0, go_in_read: 1'b0, exp_err: 1'b0, exp_drain: 1'b1, exp_reads: 9};
        vecs[2] = '{data: '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999},
                    finish_at: 8, bp: 1'b1, go_in_read: 1'b1, exp_err: 1'b0, exp_drain: 1'b1, exp_reads: 9};
        vecs[3] = '{data: '{16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17, 16'd18},
                    finish_at: 4, bp: 1'b0, go_in_read: 1'b0, exp_err: 1'b1, exp_drain: 1'b0, exp_reads: 7};
        vecs[4] = '{data: '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006, 16'hA007, 16'hA008, 16'hA009},
                    finish_at: 9, bp: 1'b0, go_in_read: 1'b0, exp_err: 1'b1, exp_drain: 1'b1, exp_reads: 9};
        vecs[5] = '{data: '{16'h0F00, 16'h0E01, 16'h0D02, 16'h0C03, 16'h0B04, 16'h0A05, 16'h0906, 16'h0807, 16'h0708},
                    finish_at: 8, bp: 1'b1, go_in_read: 1'b0, exp_err: 1'b0, exp_drain: 1'b1, exp_reads: 9};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_case(i, -1);

        // Late finish leaves err set, then reset lands in DRAIN with rd_idx=4.
        run_case(4, 4);
        run_case(0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
